// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch (SS.hh) running from the 5 MHz board clock.
// Two raw push-buttons are synchronised, debounced and edge-detected.
// The resulting pulses drive a RUN/STOP/IDLE state machine.
// A prescaler divides clk5 down to the 0.01 s count tick.
module stopwatch_bcd #(
    parameter int TICK_DIV  = 50000,
    parameter int DB_CYCLES = 50000
) (
    input  logic        clk5,
    input  logic        reset,
    input  logic        btnStartStop,
    input  logic        btnClear,
    output logic [15:0] dispVal,
    output logic        running
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Button index 0 is start/stop, index 1 is clear.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [1:0]    level_d;
    logic [1:0]    pulse;
    logic [DW-1:0] db_cnt [2];
    logic          ss_pulse;
    logic          clr_pulse;

    state_t        state_q;
    state_t        state_d;
    logic          clear_cnt;
    logic          tick;
    logic [PW-1:0] pre_q;
    logic [15:0]   bcd_next;
    logic          carry;

    assign btn_raw   = {btnClear, btnStartStop};
    assign ss_pulse  = pulse[0];
    assign clr_pulse = pulse[1];

    // Two-flop synchroniser bringing the raw buttons into the clk5 domain.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk5) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive differing samples.
    // NOTE: the per-button counter array is only two entries, so it is reset like any other flop.
    always_ff @(posedge clk5) begin
        if (reset) begin
            level <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_MAX) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Registered rising-edge detector: one pulse per accepted press, none on release.
    always_ff @(posedge clk5) begin
        if (reset) begin
            level_d <= 2'b00;
            pulse   <= 2'b00;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk5) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; clear takes priority over start/stop only when stopped.
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d   = state_q;
        clear_cnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_pulse)       state_d = RUN;
                else if (clr_pulse) clear_cnt = 1'b1;
            end
            RUN: begin
                if (ss_pulse) state_d = STOP;
            end
            STOP: begin
                if (clr_pulse) begin
                    state_d   = IDLE;
                    clear_cnt = 1'b1;
                end else if (ss_pulse) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tick = (state_q == RUN) && (pre_q == PRE_MAX);

    // BCD increment with digit-to-digit carry; 99.99 rolls over to 00.00.
    always_comb begin
        bcd_next = dispVal;
        carry    = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (bcd_next[4*d +: 4] == 4'd9) begin
                    bcd_next[4*d +: 4] = 4'd0;
                end else begin
                    bcd_next[4*d +: 4] = bcd_next[4*d +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    // Prescaler, displayed count and running flag.
    always_ff @(posedge clk5) begin
        if (reset) begin
            pre_q   <= '0;
            dispVal <= 16'h0000;
            running <= 1'b0;
        end else begin
            running <= (state_d == RUN);
            if (clear_cnt) begin
                pre_q   <= '0;
                dispVal <= 16'h0000;
            end else begin
                if (tick) dispVal <= bcd_next;
                if (state_q == RUN)
                    pre_q <= tick ? '0 : pre_q + 1'b1;
                else if (state_q == IDLE && ss_pulse)
                    pre_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with TICK_DIV=4 and DB_CYCLES=3.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_stopwatch_bcd;

    logic        clk5 = 1'b0;
    logic        reset;
    logic        btnStartStop;
    logic        btnClear;
    logic [15:0] dispVal;
    logic        running;

    int n_checks = 0;
    int n_errors = 0;
    int ss_cnt   = 0;
    int clr_cnt  = 0;
    logic bad_digit = 1'b0;

    stopwatch_bcd #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
        .clk5         (clk5),
        .reset        (reset),
        .btnStartStop (btnStartStop),
        .btnClear     (btnClear),
        .dispVal      (dispVal),
        .running      (running)
    );

    always #5 clk5 = ~clk5;

    // Count edge-detector pulses seen by the FSM.
    always @(posedge clk5) begin
        if (dut.ss_pulse)  ss_cnt++;
        if (dut.clr_pulse) clr_cnt++;
    end

    // Flag any non-decimal digit on the display.
    always @(negedge clk5) begin
        for (int d = 0; d < 4; d++)
            if (dispVal[4*d +: 4] > 4'd9) bad_digit = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk5);
        #1;
    endtask

    task automatic press(input logic ss, input logic clr, input int hold);
        btnStartStop = ss;
        btnClear     = clr;
        step(hold);
        btnStartStop = 1'b0;
        btnClear     = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        btnStartStop = 1'b0;
        btnClear     = 1'b0;

        // 1: reset
        step(2);
        check("rst_disp", 32'(dispVal), 32'h0000);
        check("rst_run",  32'(running), 32'd0);
        reset = 1'b0;
        step(5);
        check("idle_disp", 32'(dispVal), 32'h0000);
        check("idle_run",  32'(running), 32'd0);
        check("idle_ss",   32'(ss_cnt),  32'd0);
        check("idle_clr",  32'(clr_cnt), 32'd0);

        // 2: start, 7-cycle latency, 10 ticks in 40 clocks
        btnStartStop = 1'b1;
        step(6);
        check("ss_lat6", 32'(running), 32'd0);
        step(1);
        check("ss_lat7",  32'(running), 32'd1);
        check("ss_disp0", 32'(dispVal), 32'h0000);
        step(3);
        check("pre_e3", 32'(dispVal), 32'h0000);
        btnStartStop = 1'b0;
        step(1);
        check("pre_e4", 32'(dispVal), 32'h0001);
        step(36);
        check("run40_disp", 32'(dispVal), 32'h0010);
        check("run40_run",  32'(running), 32'd1);
        check("one_ss",     32'(ss_cnt),  32'd1);

        // stop: one more tick lands before the transition
        press(1'b1, 1'b0, 6);
        step(1);
        check("stop_run",  32'(running), 32'd0);
        check("stop_disp", 32'(dispVal), 32'h0011);
        step(10);
        check("stop_hold", 32'(dispVal), 32'h0011);

        // 3: clear glitch shorter than debounce window
        btnClear = 1'b1;
        step(2);
        btnClear = 1'b0;
        step(10);
        check("glitch_disp", 32'(dispVal), 32'h0011);
        check("glitch_run",  32'(running), 32'd0);
        check("glitch_clr",  32'(clr_cnt), 32'd0);

        // 4: resume from held prescaler, clear ignored in RUN, clear in STOP
        press(1'b1, 1'b0, 6);
        step(1);
        check("resume_run",  32'(running), 32'd1);
        check("resume_disp", 32'(dispVal), 32'h0011);
        step(1);
        check("resume_tick", 32'(dispVal), 32'h0012);
        press(1'b0, 1'b1, 6);
        step(2);
        check("clr_in_run_disp", 32'(dispVal), 32'h0014);
        check("clr_in_run_run",  32'(running), 32'd1);
        check("clr_in_run_cnt",  32'(clr_cnt), 32'd1);
        press(1'b1, 1'b0, 6);
        step(1);
        check("stop2_run",  32'(running), 32'd0);
        check("stop2_disp", 32'(dispVal), 32'h0015);
        press(1'b0, 1'b1, 6);
        step(1);
        check("clear_disp", 32'(dispVal), 32'h0000);
        check("clear_run",  32'(running), 32'd0);

        // 5: long run through every carry boundary and the 99.99 wrap
        press(1'b1, 1'b0, 6);
        step(1);
        check("long_run", 32'(running), 32'd1);
        step(396);
        check("c99",     32'(dispVal), 32'h0099);
        step(3);
        check("c99_hold", 32'(dispVal), 32'h0099);
        step(1);
        check("c100",    32'(dispVal), 32'h0100);
        step(3596);
        check("c999",    32'(dispVal), 32'h0999);
        step(4);
        check("c1000",   32'(dispVal), 32'h1000);
        step(35996);
        check("c9999",   32'(dispVal), 32'h9999);
        step(4);
        check("wrap",     32'(dispVal), 32'h0000);
        check("wrap_run", 32'(running), 32'd1);
        step(4);
        check("wrap_cont", 32'(dispVal), 32'h0001);
        step(488);
        check("c123", 32'(dispVal), 32'h0123);
        step(2);
        check("c123_mid", 32'(dispVal), 32'h0123);
        check("pre_mid",  32'(dut.pre_q), 32'd2);

        // 6: reset mid-run
        reset = 1'b1;
        step(1);
        check("rst_run_disp", 32'(dispVal), 32'h0000);
        check("rst_run_run",  32'(running), 32'd0);
        check("rst_run_pre",  32'(dut.pre_q), 32'd0);
        reset = 1'b0;

        // simultaneous press: STOP -> IDLE (clear wins), IDLE -> RUN
        press(1'b1, 1'b0, 6);
        step(1);
        check("x_run", 32'(running), 32'd1);
        step(20);
        check("x_disp5", 32'(dispVal), 32'h0005);
        press(1'b1, 1'b0, 6);
        step(1);
        check("x_stop_run",  32'(running), 32'd0);
        check("x_stop_disp", 32'(dispVal), 32'h0006);
        press(1'b1, 1'b1, 6);
        step(1);
        check("both_stop_disp", 32'(dispVal), 32'h0000);
        check("both_stop_run",  32'(running), 32'd0);
        step(10);
        check("both_idle_run",  32'(running), 32'd0);
        check("both_idle_disp", 32'(dispVal), 32'h0000);
        press(1'b1, 1'b1, 6);
        step(1);
        check("both_idle_start", 32'(running), 32'd1);
        step(4);
        check("both_idle_tick", 32'(dispVal), 32'h0001);

        check("bcd_digits", 32'(bad_digit), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
